palette_lookup: RTL and testbench

PALETTE_LOOKUP -- requirements
Module: palette_lookup

---
 rtl/palette_lookup.sv | 152 +++++++++++++++
 tb/tb_palette_lookup.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lookup.sv
// palette_lookup: thermal pixel to RGB palette colour stream.
//
// Each accepted pixel is windowed (floor active_min, right shift active_shift),
// saturated to a ROM index and sent to an external synchronous palette ROM.
// The ROM colour and the sof/eol tags are collected in a 4-entry output FIFO.
// Credit-based in_ready keeps the FIFO from overflowing, so the pipeline never stalls.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready/in_data       upstream pixel stream (handshake)
//   in_sof/in_eol                   frame / line tags of the input beat
//   cfg_min, cfg_shift              window floor and scale, loaded on sof beats
//   rom_addr                        registered palette ROM address
//   rom_data                        ROM colour, valid one clock after rom_addr
//   out_valid/out_ready/out_data    downstream colour stream (handshake)
//   out_sof/out_eol                 tags aligned with out_data
module palette_lookup #(
    parameter int IN_W    = 16,
    parameter int IDX_W   = 8,
    parameter int COLOR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_sof,
    input  logic               in_eol,
    input  logic [IN_W-1:0]    cfg_min,
    input  logic [3:0]         cfg_shift,
    output logic [IDX_W-1:0]   rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COLOR_W-1:0] out_data,
    output logic               out_sof,
    output logic               out_eol
);

    localparam logic [IN_W-1:0] IDX_MAX = IN_W'((2 ** IDX_W) - 1);
    localparam int              ENTRY_W = COLOR_W + 2;

    // Window, scale and saturate a raw pixel into a palette index.
    function automatic logic [IDX_W-1:0] sat_index(input logic [IN_W-1:0] pix,
                                                   input logic [IN_W-1:0] mn,
                                                   input logic [3:0]      sh);
        logic [IN_W-1:0] diff;
        logic [IN_W-1:0] scaled;
        logic [IDX_W-1:0] idx;
        diff   = pix - mn;
        scaled = diff >> sh;
        if (pix <= mn)
            idx = '0;
        else if (scaled > IDX_MAX)
            idx = '1;
        else
            idx = scaled[IDX_W-1:0];
        return idx;
    endfunction

    logic [IN_W-1:0]    active_min_q, active_min_d;
    logic [3:0]         active_shift_q, active_shift_d;
    logic [IDX_W-1:0]   rom_addr_q, rom_addr_d;
    logic               vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
    logic               sof_p0_q, sof_p0_d, eol_p0_q, eol_p0_d;
    logic               sof_p1_q, sof_p1_d, eol_p1_q, eol_p1_d;
    logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]         count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [4];
    logic [ENTRY_W-1:0] mem_wr_d;
    logic [ENTRY_W-1:0] head;

    logic              accept, push, pop;
    logic [2:0]        inflight;
    logic [IN_W-1:0]   eff_min;
    logic [3:0]        eff_shift;

    always_comb begin
        inflight  = {2'b00, vld_p0_q} + {2'b00, vld_p1_q};
        in_ready  = (count_q + inflight) < 3'd4;
        accept    = in_valid && in_ready;

        // An sof beat uses the freshly supplied configuration itself.
        eff_min   = in_sof ? cfg_min   : active_min_q;
        eff_shift = in_sof ? cfg_shift : active_shift_q;

        active_min_d   = active_min_q;
        active_shift_d = active_shift_q;
        if (accept && in_sof) begin
            active_min_d   = cfg_min;
            active_shift_d = cfg_shift;
        end

        // Stage p0: index registered into rom_addr, ROM read under way
        rom_addr_d = accept ? sat_index(in_data, eff_min, eff_shift) : rom_addr_q;
        vld_p0_d   = accept;
        sof_p0_d   = in_sof;
        eol_p0_d   = in_eol;

        // Stage p1: rom_data valid, pushed into the FIFO on the next edge
        vld_p1_d   = vld_p0_q;
        sof_p1_d   = sof_p0_q;
        eol_p1_d   = eol_p0_q;

        push     = vld_p1_q;
        pop      = (count_q != 3'd0) && out_ready;
        mem_wr_d = {sof_p1_q, eol_p1_q, rom_data};
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q + {2'b00, push} - {2'b00, pop};

        head      = mem_q[rd_ptr_q];
        out_valid = (count_q != 3'd0);
        // Gate the head so the outputs read zero whenever the FIFO is empty.
        out_data  = out_valid ? head[COLOR_W-1:0] : '0;
        out_sof   = out_valid && head[ENTRY_W-1];
        out_eol   = out_valid && head[ENTRY_W-2];
        rom_addr  = rom_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_min_q   <= '0;
            active_shift_q <= '0;
            rom_addr_q     <= '0;
            vld_p0_q       <= 1'b0;
            vld_p1_q       <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            active_min_q   <= active_min_d;
            active_shift_q <= active_shift_d;
            rom_addr_q     <= rom_addr_d;
            vld_p0_q       <= vld_p0_d;
            vld_p1_q       <= vld_p1_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        sof_p0_q <= sof_p0_d;
        eol_p0_q <= eol_p0_d;
        sof_p1_q <= sof_p1_d;
        eol_p1_q <= eol_p1_d;
        if (push)
            mem_q[wr_ptr_q] <= mem_wr_d;
    end

endmodule

// File: tb/tb_palette_lookup.sv
module tb_palette_lookup;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sof;
    logic        in_eol;
    logic [15:0] cfg_min;
    logic [3:0]  cfg_shift;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_sof;
    logic        out_eol;

    palette_lookup #(.IN_W(16), .IDX_W(8), .COLOR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eol(in_eol),
        .cfg_min(cfg_min), .cfg_shift(cfg_shift),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol)
    );

    always #5 clk = ~clk;

    // Palette contents: 37 is odd, so every address maps to a distinct colour.
    function automatic logic [11:0] rom_f(input int a);
        return 12'((a * 37 + 5) & 12'hFFF);
    endfunction

    always @(posedge clk) rom_data <= rom_f(int'(rom_addr));

    // Reference index straight from the windowing rules.
    function automatic int ref_idx(input int pix, input int mn, input int sh);
        int q;
        if (pix <= mn) return 0;
        q = (pix - mn) / (1 << sh);
        return (q > 255) ? 255 : q;
    endfunction

    typedef struct {
        logic [11:0] c;
        logic        s;
        logic        e;
        int          t;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    act_min = 0;
    int    act_shift = 0;
    int    last_idx = 0;
    int    acc_total = 0;
    logic  last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes, advance the model, check the outputs.
    task automatic cycle();
        logic  acc, pp;
        int    mn, sh, idx;
        beat_t b;
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        @(posedge clk);
        cyc++;
        if (pp && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            mn  = in_sof ? int'(cfg_min)   : act_min;
            sh  = in_sof ? int'(cfg_shift) : act_shift;
            act_min   = mn;
            act_shift = sh;
            idx = ref_idx(int'(in_data), mn, sh);
            last_idx = idx;
            b.c = rom_f(idx);
            b.s = in_sof;
            b.e = in_eol;
            b.t = cyc;
            q.push_back(b);
            acc_total++;
        end
        last_acc = acc;
        #1;
        chk("in_ready", in_ready, q.size() < 4);
        chk("rom_addr", rom_addr, last_idx);
        if (q.size() > 0 && cyc - q[0].t >= 2) begin
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, q[0].c);
            chk("out_sof", out_sof, q[0].s);
            chk("out_eol", out_eol, q[0].e);
        end else begin
            chk("out_valid", out_valid, 0);
        end
    endtask

    task automatic drive(input logic v, input int pix, input logic s, input logic e);
        in_valid = v;
        in_data  = 16'(pix);
        in_sof   = s;
        in_eol   = e;
        cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        cyc++;
        q.delete();
        act_min = 0; act_shift = 0; last_idx = 0;
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sof", out_sof, 0);
        chk("rst_out_eol", out_eol, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        int stall_acc;
        int start_acc;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0; in_eol = 1'b0;
        cfg_min = '0; cfg_shift = '0; out_ready = 1'b1;
        @(posedge clk);
        apply_reset();

        // sof beat 1123 with min 100, shift 2 -> index 255, out two edges later
        cfg_min = 16'd100; cfg_shift = 4'd2;
        drive(1'b1, 1123, 1'b1, 1'b0);
        chk("req024_addr", rom_addr, 255);
        idle(1);
        chk("req024_notyet", out_valid, 0);
        idle(1);
        chk("req024_valid", out_valid, 1);
        chk("req024_data", out_data, rom_f(255));
        chk("req024_sof", out_sof, 1);
        idle(2);

        // Floor and saturation boundaries
        cfg_shift = 4'd0;
        drive(1'b1, 50, 1'b1, 1'b0);   chk("idx_50", rom_addr, 0);
        drive(1'b1, 2000, 1'b0, 1'b0); chk("idx_2000", rom_addr, 255);
        drive(1'b1, 356, 1'b0, 1'b0);  chk("idx_356", rom_addr, 255);
        drive(1'b1, 355, 1'b0, 1'b1);  chk("idx_355", rom_addr, 255);
        drive(1'b1, 354, 1'b0, 1'b0);  chk("idx_354", rom_addr, 254);
        drive(1'b1, 100, 1'b0, 1'b0);  chk("idx_100", rom_addr, 0);
        idle(4);

        // Mid-frame cfg change is ignored until the next sof
        cfg_min = 16'd100; cfg_shift = 4'd2;
        drive(1'b1, 600, 1'b1, 1'b0);  chk("cfg_sof100", rom_addr, 125);
        cfg_min = 16'd500;
        drive(1'b1, 600, 1'b0, 1'b0);  chk("cfg_mid", rom_addr, 125);
        drive(1'b1, 600, 1'b1, 1'b0);  chk("cfg_sof500", rom_addr, 25);
        drive(1'b1, 700, 1'b0, 1'b1);  chk("cfg_after", rom_addr, 50);
        idle(4);

        // Backpressure: exactly four beats fit, then streaming resumes
        out_ready = 1'b0;
        stall_acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 100 + 4 * i, i == 0, i == 7);
            stall_acc += int'(last_acc);
        end
        chk("stall_accepts", stall_acc, 4);
        chk("stall_ready", in_ready, 0);
        out_ready = 1'b1;
        start_acc = acc_total;
        for (int i = 0; i < 12; i++) drive(1'b1, 200 + 8 * i, 1'b0, 1'b0);
        // Twelve cycles of streaming after the drain should lose at most the restart slots
        chk("stream_rate", (acc_total - start_acc) >= 9, 1);
        idle(4);

        // Random stream against the model
        start_acc = acc_total;
        for (int i = 0; i < 6000 && (acc_total - start_acc) < 1000; i++) begin
            cfg_min   = 16'($urandom_range(0, 4000));
            cfg_shift = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 65535),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end
        chk("rand_done", (acc_total - start_acc) >= 1000, 1);
        out_ready = 1'b1;
        idle(8);
        chk("rand_drained", q.size(), 0);

        // Reset with three beats buffered discards them
        out_ready = 1'b0;
        cfg_min = 16'd0; cfg_shift = 4'd0;
        drive(1'b1, 10, 1'b1, 1'b0);
        drive(1'b1, 20, 1'b0, 1'b0);
        drive(1'b1, 30, 1'b0, 1'b1);
        idle(3);
        chk("pre_rst_valid", out_valid, 1);
        apply_reset();
        out_ready = 1'b1;
        idle(5);
        drive(1'b1, 40, 1'b1, 1'b1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
